adma_data_mover: RTL and testbench

- Data-transfer engine that executes the ST_TFR phase of the ADMA state machine.
- Given one TRAN descriptor (address, byte length, direction), it moves 32-bit words between system memory and the SD data FIFOs:
  - Host-to-card: memory to TX FIFO.
  - Card-to-host: RX FIFO to memory.
- Honours stop-at-block-gap / continue at block boundaries.
- Pulses tfc to the ADMA controller when the descriptor length is exhausted.

---
 rtl/adma_pkg.sv | 36 +++
 rtl/adma_data_mover_if.sv | 40 ++++
 rtl/adma_xfer_counter.sv | 70 +++++++
 rtl/adma_data_mover.sv | 174 +++++++++++++++++
 tb/tb_adma_data_mover.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adma_pkg.sv
// adma_pkg: shared constants for the ADMA data mover.
// Holds bus widths, the one-hot state encoding used throughout the ADMA
// controller, the direction encoding and the descriptor-length decode helper.
package adma_pkg;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 32;
  localparam int WORDS_W = 15;  // remaining-word counter, holds up to 16384
  localparam int BLKW_W  = 10;  // block size in words, block_size[11:2]

  localparam logic [ADDR_W-1:0] WORD_BYTES = 64'd4;

  typedef logic [4:0] state_t;

  // One-hot state encoding, kept in line with the ADMA controller.
  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_SRC  = 5'b00010;
  localparam logic [4:0] ST_DST  = 5'b00100;
  localparam logic [4:0] ST_GAP  = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;

  localparam logic CARD_TO_HOST = 1'b1;
  localparam logic HOST_TO_CARD = 1'b0;

  // Descriptor length (bytes) to word count; a zero length encodes 65536 bytes.
  function automatic logic [WORDS_W-1:0] calc_words(input logic [15:0] len);
    logic [WORDS_W-1:0] w;
    if (len == 16'd0) begin
      w = 15'd16384;
    end else begin
      w = {1'b0, len[15:2]};
    end
    return w;
  endfunction

endpackage

// File: rtl/adma_data_mover_if.sv
// adma_data_mover_if: memory bus and SD FIFO signals of the ADMA data mover.
//   mem_*  : request/ack system memory port (req held until one-cycle ack)
//   rxf_*  : RX FIFO read side, first-word-fall-through
//   txf_*  : TX FIFO write side
// modport master is the data mover, modport slave is the memory/FIFO side.
interface adma_data_mover_if;
  import adma_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              rxf_empty;
  logic [DATA_W-1:0] rxf_rdata;
  logic              rxf_rd;
  logic              txf_full;
  logic [DATA_W-1:0] txf_wdata;
  logic              txf_wr;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    input  rxf_empty, rxf_rdata,
    output rxf_rd,
    input  txf_full,
    output txf_wdata, txf_wr
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    output rxf_empty, rxf_rdata,
    input  rxf_rd,
    output txf_full,
    input  txf_wdata, txf_wr
  );

endinterface

// File: rtl/adma_xfer_counter.sv
// adma_xfer_counter: remaining-word and in-block word counters of a transfer.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : latch words_i / blk_words_i and clear the block counter
//   clear_i       : abort, zero everything (wins over load and step)
//   step_i        : one word completed
//   words_i       : descriptor length in words (1..16384)
//   blk_words_i   : block size in words, 0 disables boundaries
//   last_o        : the word in flight is the last of the descriptor
//   boundary_o    : the word in flight closes a block
module adma_xfer_counter
  import adma_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic [WORDS_W-1:0] words_i,
  input  logic [BLKW_W-1:0]  blk_words_i,
  output logic               last_o,
  output logic               boundary_o
);

  logic [WORDS_W-1:0] words_q, words_d;
  logic [BLKW_W-1:0]  blk_words_q, blk_words_d;
  logic [BLKW_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic               boundary_s;

  // blk_cnt counts words already done in this block, so the in-flight word
  // closes the block when one more reaches the block size.
  assign boundary_s = (blk_words_q != 10'd0) && ((blk_cnt_q + 10'd1) == blk_words_q);
  assign boundary_o = boundary_s;
  assign last_o     = (words_q == 15'd1);

  // Counter next-state: clear, load, step or hold.
  always_comb begin
    words_d     = words_q;
    blk_words_d = blk_words_q;
    blk_cnt_d   = blk_cnt_q;
    if (clear_i) begin
      words_d     = 15'd0;
      blk_words_d = 10'd0;
      blk_cnt_d   = 10'd0;
    end else if (load_i) begin
      words_d     = words_i;
      blk_words_d = blk_words_i;
      blk_cnt_d   = 10'd0;
    end else if (step_i) begin
      words_d   = words_q - 15'd1;
      blk_cnt_d = boundary_s ? 10'd0 : (blk_cnt_q + 10'd1);
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q     <= 15'd0;
      blk_words_q <= 10'd0;
      blk_cnt_q   <= 10'd0;
    end else begin
      words_q     <= words_d;
      blk_words_q <= blk_words_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

endmodule

// File: rtl/adma_data_mover.sv
// adma_data_mover: executes the transfer phase of one ADMA TRAN descriptor,
// moving 32-bit words between system memory and the SD data FIFOs.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse, latch descriptor (ignored while busy)
//   dat_adr/dat_len   : descriptor address / byte length (0 = 65536)
//   dir_c2h           : 1 = RX FIFO -> memory, 0 = memory -> TX FIFO
//   block_size        : SD block size in bytes, 0 disables block gaps
//   stop_at_gap       : pause at the next block boundary
//   continue_req      : resume from a block gap
//   abort             : synchronous abort back to IDLE, no completion pulse
//   bus               : memory and FIFO ports (master side)
//   busy              : transfer in progress
//   gap_stopped       : paused at a block gap
//   block_done        : one-cycle pulse after each block boundary word
//   tfc               : one-cycle pulse when the descriptor is exhausted
module adma_data_mover
  import adma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dat_adr,
  input  logic [15:0]       dat_len,
  input  logic              dir_c2h,
  input  logic [11:0]       block_size,
  input  logic              stop_at_gap,
  input  logic              continue_req,
  input  logic              abort,
  adma_data_mover_if.master bus,
  output logic              busy,
  output logic              gap_stopped,
  output logic              block_done,
  output logic              tfc
);

  state_t            state_q, state_d, nxt_state_s;
  logic [ADDR_W-1:0] addr_q, addr_d, nxt_addr_s;
  logic [DATA_W-1:0] data_q, data_d, nxt_data_s;
  logic              dir_q, dir_d;
  logic              block_done_q, block_done_d, nxt_block_done_s;

  logic               c2h_s, in_src_s, in_dst_s;
  logic               abort_s, accept_s;
  logic               src_hit_s, dst_hit_s;
  logic               last_s, boundary_s;
  logic [WORDS_W-1:0] words_init_s;
  logic               unused_ok_s;

  // Address and block size are word granular; the byte offsets are dropped.
  assign unused_ok_s = &{1'b0, dat_adr[1:0], block_size[1:0]};

  assign words_init_s = calc_words(dat_len);
  assign c2h_s        = (dir_q == CARD_TO_HOST);
  assign in_src_s     = (state_q == ST_SRC);
  assign in_dst_s     = (state_q == ST_DST);
  assign abort_s      = abort & (state_q != ST_IDLE);
  // Abort beats a simultaneous start, even from IDLE.
  assign accept_s     = start & ~abort & (state_q == ST_IDLE);

  // SRC completes on a FIFO word (c2h) or a read ack (h2c); DST completes on
  // a write ack (c2h) or a TX push (h2c). DST completion is word completion.
  assign src_hit_s = in_src_s & ~abort_s & (c2h_s ? ~bus.rxf_empty : bus.mem_ack);
  assign dst_hit_s = in_dst_s & ~abort_s & (c2h_s ? bus.mem_ack : ~bus.txf_full);

  adma_xfer_counter u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept_s),
    .clear_i     (abort_s),
    .step_i      (dst_hit_s),
    .words_i     (words_init_s),
    .blk_words_i (block_size[11:2]),
    .last_o      (last_s),
    .boundary_o  (boundary_s)
  );

  // Handshake strobes are decoded from the state register and gated by abort
  // so they drop in the abort cycle itself.
  assign bus.mem_req   = ~abort_s & ((in_src_s & ~c2h_s) | (in_dst_s & c2h_s));
  assign bus.mem_we    = ~abort_s & in_dst_s & c2h_s;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = data_q;
  assign bus.rxf_rd    = src_hit_s & c2h_s;
  assign bus.txf_wr    = dst_hit_s & ~c2h_s;
  assign bus.txf_wdata = data_q;

  assign busy        = (state_q != ST_IDLE);
  assign gap_stopped = (state_q == ST_GAP);
  assign tfc         = (state_q == ST_DONE);
  assign block_done  = block_done_q;

  // Transfer FSM next state, address advance and data capture.
  always_comb begin
    nxt_state_s      = state_q;
    nxt_addr_s       = addr_q;
    nxt_data_s       = data_q;
    nxt_block_done_s = 1'b0;
    dir_d            = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          nxt_addr_s  = {dat_adr[ADDR_W-1:2], 2'b00};
          dir_d       = dir_c2h;
          // Lengths of 1..3 bytes hold no whole word: complete at once.
          nxt_state_s = (words_init_s == 15'd0) ? ST_DONE : ST_SRC;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_SRC: begin
        if (src_hit_s) begin
          nxt_data_s  = c2h_s ? bus.rxf_rdata : bus.mem_rdata;
          nxt_state_s = ST_DST;
        end else begin
          nxt_state_s = ST_SRC;
        end
      end
      ST_DST: begin
        if (dst_hit_s) begin
          nxt_addr_s       = addr_q + WORD_BYTES;
          nxt_block_done_s = boundary_s;
          // Descriptor end wins over a pending block gap.
          if (last_s) begin
            nxt_state_s = ST_DONE;
          end else if (boundary_s && stop_at_gap) begin
            nxt_state_s = ST_GAP;
          end else begin
            nxt_state_s = ST_SRC;
          end
        end else begin
          nxt_state_s = ST_DST;
        end
      end
      ST_GAP: begin
        if (continue_req && !stop_at_gap) begin
          nxt_state_s = ST_SRC;
        end else begin
          nxt_state_s = ST_GAP;
        end
      end
      ST_DONE: begin
        nxt_state_s = ST_IDLE;
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // Abort overrides whatever the FSM chose and clears the datapath.
  assign state_d      = abort_s ? ST_IDLE : nxt_state_s;
  assign addr_d       = abort_s ? {ADDR_W{1'b0}} : nxt_addr_s;
  assign data_d       = abort_s ? {DATA_W{1'b0}} : nxt_data_s;
  assign block_done_d = abort_s ? 1'b0 : nxt_block_done_s;

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      dir_q        <= HOST_TO_CARD;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      dir_q        <= dir_d;
      block_done_q <= block_done_d;
    end
  end

endmodule

// File: tb/tb_adma_data_mover.sv
// tb_adma_data_mover: directed bench for adma_data_mover with a simple
// memory model (read data = {16'hC0DE, addr[15:0]}), an RX FIFO array and a
// TX FIFO whose full flag is driven by the bench.
module tb_adma_data_mover;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] dat_adr = 64'd0;
  logic [15:0] dat_len = 16'd0;
  logic        dir_c2h = 1'b0;
  logic [11:0] block_size = 12'd0;
  logic        stop_at_gap = 1'b0;
  logic        continue_req = 1'b0;
  logic        abort = 1'b0;
  logic        busy, gap_stopped, block_done, tfc;

  logic        ack_en = 1'b1;
  logic        txf_full_v = 1'b0;
  logic [31:0] rx_mem [0:15];
  logic [4:0]  rx_wr_cnt = 5'd0;
  logic [4:0]  rx_ptr = 5'd0;

  int total = 0;
  int bad = 0;

  // Monitor logs
  logic [63:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [63:0] rd_addr [0:63];
  logic [31:0] tx_data [0:63];
  logic [63:0] last_rd_addr = 64'd0;
  int wr_n = 0, rd_n = 0, tx_n = 0, rxrd_n = 0, tfc_n = 0, bd_n = 0, gap_n = 0;

  adma_data_mover_if bus ();

  assign bus.mem_ack   = bus.mem_req & ack_en;
  assign bus.mem_rdata = {16'hC0DE, bus.mem_addr[15:0]};
  assign bus.rxf_empty = (rx_ptr == rx_wr_cnt);
  assign bus.rxf_rdata = rx_mem[rx_ptr[3:0]];
  assign bus.txf_full  = txf_full_v;

  adma_data_mover dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dat_adr      (dat_adr),
    .dat_len      (dat_len),
    .dir_c2h      (dir_c2h),
    .block_size   (block_size),
    .stop_at_gap  (stop_at_gap),
    .continue_req (continue_req),
    .abort        (abort),
    .bus          (bus),
    .busy         (busy),
    .gap_stopped  (gap_stopped),
    .block_done   (block_done),
    .tfc          (tfc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rxf_rd) rx_ptr <= rx_ptr + 5'd1;
  end

  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = bus.mem_addr;
        wr_data[wr_n] = bus.mem_wdata;
      end
      wr_n++;
    end
    if (bus.mem_req && bus.mem_ack && !bus.mem_we) begin
      if (rd_n < 64) rd_addr[rd_n] = bus.mem_addr;
      last_rd_addr = bus.mem_addr;
      rd_n++;
    end
    if (bus.txf_wr) begin
      if (tx_n < 64) tx_data[tx_n] = bus.txf_wdata;
      tx_n++;
    end
    if (bus.rxf_rd) rxrd_n++;
    if (tfc) tfc_n++;
    if (block_done) bd_n++;
    if (gap_stopped) gap_n++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [63:0] adr, input logic [15:0] len, input logic c2h,
                    input logic [11:0] bs);
    @(posedge clk); #1;
    dat_adr = adr; dat_len = len; dir_c2h = c2h; block_size = bs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for tfc within a cycle budget, then require busy low one cycle later.
  task automatic wait_tfc(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tfc) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_tfc_seen"}, {63'd0, seen}, 64'd1);
    tick();
    chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int b_wr, b_rd, b_tx, b_rx, b_tfc, b_bd, b_gap;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tfc", {63'd0, tfc}, 64'd0);
    chk("rst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_addr", bus.mem_addr, 64'd0);
    rst_n = 1'b1;

    // 1: card-to-host, 4 words from RX FIFO
    rx_mem[0] = 32'h0000_00A0; rx_mem[1] = 32'h0000_00A1;
    rx_mem[2] = 32'h0000_00A2; rx_mem[3] = 32'h0000_00A3;
    rx_wr_cnt = 5'd4;
    b_wr = wr_n; b_rx = rxrd_n; b_tfc = tfc_n;
    go(64'h1000, 16'd16, 1'b1, 12'd512);
    wait_tfc("c2h", 40);
    chk("c2h_wr_cnt", 64'(wr_n - b_wr), 64'd4);
    chk("c2h_rxrd_cnt", 64'(rxrd_n - b_rx), 64'd4);
    chk("c2h_tfc_cnt", 64'(tfc_n - b_tfc), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("c2h_addr", wr_addr[b_wr + i], 64'h1000 + 64'(4 * i));
      chk("c2h_data", {32'd0, wr_data[b_wr + i]}, 64'hA0 + 64'(i));
    end

    // 2: host-to-card, TX full stalls the push
    txf_full_v = 1'b1;
    b_rd = rd_n; b_tx = tx_n; b_tfc = tfc_n;
    go(64'hFFFF_0000_0000_2003, 16'd8, 1'b0, 12'd512);
    repeat (5) tick();
    chk("h2c_stall_tx", 64'(tx_n - b_tx), 64'd0);
    chk("h2c_stall_rd", 64'(rd_n - b_rd), 64'd1);
    chk("h2c_stall_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    txf_full_v = 1'b0;
    wait_tfc("h2c", 40);
    chk("h2c_tx_cnt", 64'(tx_n - b_tx), 64'd2);
    chk("h2c_rd0", rd_addr[b_rd], 64'hFFFF_0000_0000_2000);
    chk("h2c_rd1", rd_addr[b_rd + 1], 64'hFFFF_0000_0000_2004);
    chk("h2c_tx0", {32'd0, tx_data[b_tx]}, 64'hC0DE_2000);
    chk("h2c_tx1", {32'd0, tx_data[b_tx + 1]}, 64'hC0DE_2004);
    chk("h2c_tfc_cnt", 64'(tfc_n - b_tfc), 64'd1);

    // 3: block gap, 2-word blocks, 6 words
    b_tx = tx_n; b_bd = bd_n; b_tfc = tfc_n;
    stop_at_gap = 1'b1;
    go(64'h4000, 16'd24, 1'b0, 12'd8);
    for (int i = 0; i < 50 && !gap_stopped; i++) tick();
    chk("gap_reached", {63'd0, gap_stopped}, 64'd1);
    chk("gap_tx_cnt", 64'(tx_n - b_tx), 64'd2);
    chk("gap_bd_cnt", 64'(bd_n - b_bd), 64'd1);
    repeat (3) tick();
    chk("gap_hold", {63'd0, gap_stopped}, 64'd1);
    chk("gap_hold_tx", 64'(tx_n - b_tx), 64'd2);
    @(posedge clk); #1;
    stop_at_gap = 1'b0; continue_req = 1'b1;
    wait_tfc("gap", 60);
    continue_req = 1'b0;
    chk("gap_tx_total", 64'(tx_n - b_tx), 64'd6);
    chk("gap_bd_total", 64'(bd_n - b_bd), 64'd3);
    chk("gap_word3", {32'd0, tx_data[b_tx + 2]}, 64'hC0DE_4008);
    chk("gap_word6", {32'd0, tx_data[b_tx + 5]}, 64'hC0DE_4014);
    chk("gap_tfc_cnt", 64'(tfc_n - b_tfc), 64'd1);

    // 3b: boundary on the last word ends the descriptor, no gap
    b_bd = bd_n; b_gap = gap_n; b_tfc = tfc_n;
    stop_at_gap = 1'b1;
    go(64'h4800, 16'd8, 1'b0, 12'd8);
    wait_tfc("lastgap", 40);
    stop_at_gap = 1'b0;
    chk("lastgap_gap_cyc", 64'(gap_n - b_gap), 64'd0);
    chk("lastgap_bd", 64'(bd_n - b_bd), 64'd1);

    // 4: sub-word length completes immediately
    b_tx = tx_n; b_rd = rd_n;
    go(64'h6000, 16'd2, 1'b0, 12'd0);
    wait_tfc("zero_words", 3);
    chk("zero_words_rd", 64'(rd_n - b_rd), 64'd0);

    // 5: abort and start together in IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    tick();
    chk("abort_start_idle", {63'd0, busy}, 64'd0);

    // 6: abort while a read is pending
    ack_en = 1'b0;
    b_tfc = tfc_n;
    go(64'h7000, 16'd16, 1'b0, 12'd8);
    tick();
    chk("abort_req_pre", {63'd0, bus.mem_req}, 64'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    chk("abort_req_low", {63'd0, bus.mem_req}, 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    ack_en = 1'b1;
    tick();
    chk("abort_idle", {63'd0, busy}, 64'd0);
    chk("abort_addr_clr", bus.mem_addr, 64'd0);
    chk("abort_no_tfc", 64'(tfc_n - b_tfc), 64'd0);
    b_tx = tx_n; b_bd = bd_n;
    go(64'h3000, 16'd8, 1'b0, 12'd8);
    wait_tfc("post_abort", 40);
    chk("post_abort_tx0", {32'd0, tx_data[b_tx]}, 64'hC0DE_3000);
    chk("post_abort_bd", 64'(bd_n - b_bd), 64'd1);

    // 7: asynchronous reset while stalled in DST
    txf_full_v = 1'b1;
    go(64'h5000, 16'd8, 1'b0, 12'd0);
    repeat (3) tick();
    chk("rstmid_busy_pre", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_addr", bus.mem_addr, 64'd0);
    chk("rstmid_txdata", {32'd0, bus.txf_wdata}, 64'd0);
    chk("rstmid_req", {63'd0, bus.mem_req}, 64'd0);
    go(64'h5000, 16'd8, 1'b0, 12'd0);
    tick();
    chk("rstmid_start_ign", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    txf_full_v = 1'b0;
    tick();
    chk("rstmid_release", {63'd0, busy}, 64'd0);

    // 8: full 64 KiB descriptor, no block boundaries
    b_tx = tx_n; b_bd = bd_n; b_tfc = tfc_n;
    go(64'h0010_0000, 16'd0, 1'b0, 12'd0);
    wait_tfc("max_len", 40000);
    chk("max_tx_cnt", 64'(tx_n - b_tx), 64'd16384);
    chk("max_last_addr", last_rd_addr, 64'h0010_FFFC);
    chk("max_bd", 64'(bd_n - b_bd), 64'd0);
    chk("max_tfc", 64'(tfc_n - b_tfc), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
